dmi_guard: RTL and testbench

- Core-clock DMI stage between the JTAG DTM's core-side request/response port and the debug module (dm_top).
- Enforces the lock policy a second time, on the core side: reads are forwarded only to addresses below ProtReadMin while locked; writes are forwarded only while unlocked.
- Blocked, malformed and timed-out transactions get locally synthesized responses, so the DTM never stalls.
- One outstanding transaction at a time.

---
 rtl/dmi_guard_pkg.sv | 65 ++++++
 rtl/dmi_guard.sv | 129 ++++++++++++
 tb/tb_dmi_guard.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_guard_pkg.sv
// Debug-module interface types shared with the DTM/DM, plus the request
// classification used by dmi_guard.
package dm;
    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DmiOk   = 2'd0,
        DmiErr  = 2'd2,
        DmiBusy = 2'd3
    } dmi_resp_e;

    localparam logic [6:0] DmiAddrSbcs = 7'h38;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;
endpackage

package dmi_guard_pkg;
    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StFwd      = 3'd1;
    localparam logic [2:0] StWaitResp = 3'd2;
    localparam logic [2:0] StDeny     = 3'd3;
    localparam logic [2:0] StRespOut  = 3'd4;

    typedef struct packed {
        logic          fwd;
        dm::dmi_resp_e code;
    } verdict_t;

    // First matching rule wins; a busy answer only follows a well-formed op.
    function automatic verdict_t classify(input dm::dtm_op_e op,
                                          input logic        late_pending,
                                          input logic        unlocked,
                                          input logic [6:0]  addr,
                                          input logic [6:0]  prot_read_min);
        verdict_t v;
        v.fwd  = 1'b0;
        v.code = dm::DmiErr;
        if (op != dm::DTM_READ && op != dm::DTM_WRITE) begin
            v.code = dm::DmiErr;
        end else if (late_pending) begin
            v.code = dm::DmiBusy;
        end else if (op == dm::DTM_WRITE && !unlocked) begin
            v.code = dm::DmiErr;
        end else if (op == dm::DTM_READ && !unlocked && addr >= prot_read_min) begin
            v.code = dm::DmiErr;
        end else begin
            v.fwd  = 1'b1;
            v.code = dm::DmiOk;
        end
        return v;
    endfunction
endpackage

// File: rtl/dmi_guard.sv
// Core-side DMI lock enforcement between the DTM and the debug module; blocked,
// malformed and timed-out transactions are answered locally.
module dmi_guard
    import dmi_guard_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter logic [6:0]  ProtReadMin   = dm::DmiAddrSbcs,
    parameter int unsigned DenyCntWidth  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    unlock_set_i,
    input  logic                    lock_clr_i,
    input  dm::dmi_req_t            req_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    output dm::dmi_resp_t           resp_o,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output dm::dmi_req_t            dm_req_o,
    output logic                    dm_req_valid_o,
    input  logic                    dm_req_ready_i,
    input  dm::dmi_resp_t           dm_resp_i,
    input  logic                    dm_resp_valid_i,
    output logic                    dm_resp_ready_o,
    output logic                    unlocked_o,
    output logic                    timeout_o,
    output logic [DenyCntWidth-1:0] deny_cnt_o
);
    localparam int unsigned      TimerW   = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TimeoutCycles - 1);

    logic [2:0]              state_q;
    logic                    unlocked_q;
    logic                    late_pending_q;
    logic [TimerW-1:0]       timer_q;
    logic [DenyCntWidth-1:0] deny_cnt_q;
    logic                    timeout_q;
    logic [1:0]              deny_code_q;
    dm::dmi_req_t            dm_req_q;
    dm::dmi_resp_t           resp_q;
    verdict_t                verdict;

    assign verdict = classify(req_i.op, late_pending_q, unlocked_q, req_i.addr, ProtReadMin);

    // Ready signals are forced low while reset is held, not just after it.
    assign req_ready_o     = (state_q == StIdle) && !rst_i;
    assign dm_resp_ready_o = !rst_i;
    assign dm_req_valid_o  = (state_q == StFwd);
    assign resp_valid_o    = (state_q == StRespOut);
    assign dm_req_o        = dm_req_q;
    assign resp_o          = resp_q;
    assign unlocked_o      = unlocked_q;
    assign timeout_o       = timeout_q;
    assign deny_cnt_o      = deny_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            unlocked_q     <= 1'b0;
            late_pending_q <= 1'b0;
            timer_q        <= '0;
            deny_cnt_q     <= '0;
            timeout_q      <= 1'b0;
            deny_code_q    <= 2'd0;
            dm_req_q       <= '0;
            resp_q         <= '0;
        end else begin
            timeout_q  <= 1'b0;
            unlocked_q <= lock_clr_i ? 1'b0 : (unlock_set_i ? 1'b1 : unlocked_q);
            // A late DM answer is swallowed wherever it lands outside WaitResp.
            if (dm_resp_valid_i && late_pending_q && state_q != StWaitResp) begin
                late_pending_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        dm_req_q <= req_i;
                        timer_q  <= '0;
                        if (verdict.fwd) begin
                            state_q <= StFwd;
                        end else begin
                            state_q     <= StDeny;
                            deny_code_q <= verdict.code;
                            if (deny_cnt_q != '1) begin
                                deny_cnt_q <= deny_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                StFwd: begin
                    if (dm_req_ready_i) begin
                        state_q <= StWaitResp;
                        timer_q <= '0;
                    end else if (timer_q == TimerMax) begin
                        state_q   <= StRespOut;
                        resp_q    <= '{data: 32'd0, resp: dm::DmiErr};
                        timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StWaitResp: begin
                    if (dm_resp_valid_i) begin
                        state_q <= StRespOut;
                        resp_q  <= dm_resp_i;
                    end else if (timer_q == TimerMax) begin
                        state_q        <= StRespOut;
                        resp_q         <= '{data: 32'd0, resp: dm::DmiErr};
                        timeout_q      <= 1'b1;
                        late_pending_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StDeny: begin
                    state_q <= StRespOut;
                    resp_q  <= '{data: 32'd0, resp: deny_code_q};
                end
                StRespOut: begin
                    if (resp_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_dmi_guard.sv
// Directed testbench for dmi_guard: lock policy, deny/timeout responses,
// late-response tracking, counter saturation, backpressure and reset.
module tb_dmi_guard;
    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          unlock_set_i, lock_clr_i;
    dm::dmi_req_t  req_i;
    logic          req_valid_i, req_ready_o;
    dm::dmi_resp_t resp_o;
    logic          resp_valid_o, resp_ready_i;
    dm::dmi_req_t  dm_req_o;
    logic          dm_req_valid_o, dm_req_ready_i;
    dm::dmi_resp_t dm_resp_i;
    logic          dm_resp_valid_i, dm_resp_ready_o;
    logic          unlocked_o, timeout_o;
    logic [7:0]    deny_cnt_o;

    int tests_run = 0;
    int failures  = 0;
    int exp_deny  = 0;

    dmi_guard dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .unlock_set_i(unlock_set_i), .lock_clr_i(lock_clr_i),
        .req_i(req_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .resp_o(resp_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .dm_req_o(dm_req_o), .dm_req_valid_o(dm_req_valid_o), .dm_req_ready_i(dm_req_ready_i),
        .dm_resp_i(dm_resp_i), .dm_resp_valid_i(dm_resp_valid_i), .dm_resp_ready_o(dm_resp_ready_o),
        .unlocked_o(unlocked_o), .timeout_o(timeout_o), .deny_cnt_o(deny_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic send(input logic [6:0] addr, input dm::dtm_op_e op, input logic [31:0] data);
        req_i.addr  = addr;
        req_i.op    = op;
        req_i.data  = data;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic dm_answer(input logic [31:0] data, input logic [1:0] code);
        dm_req_ready_i = 1'b1;
        @(negedge clk_i);
        dm_req_ready_i  = 1'b0;
        dm_resp_i       = '{data: data, resp: code};
        dm_resp_valid_i = 1'b1;
        @(negedge clk_i);
        dm_resp_valid_i = 1'b0;
    endtask

    task automatic finish_resp();
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
    endtask

    task automatic pulse_unlock();
        unlock_set_i = 1'b1;
        @(negedge clk_i);
        unlock_set_i = 1'b0;
    endtask

    task automatic pulse_lock();
        lock_clr_i = 1'b1;
        @(negedge clk_i);
        lock_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; unlock_set_i = 0; lock_clr_i = 0; req_i = '0; req_valid_i = 0;
        resp_ready_i = 0; dm_req_ready_i = 0; dm_resp_i = '0; dm_resp_valid_i = 0;
        repeat (3) @(negedge clk_i);
        tests_run++;
        if ({req_ready_o, resp_valid_o, dm_req_valid_o, dm_resp_ready_o, timeout_o, unlocked_o} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {req_ready_o, resp_valid_o, dm_req_valid_o, dm_resp_ready_o, timeout_o, unlocked_o});
        end
        tests_run++;
        if (resp_o !== '0 || dm_req_o !== '0 || deny_cnt_o !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: resp %h dm_req %h cnt %0d expected all 0", resp_o, dm_req_o, deny_cnt_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        tests_run++;
        if (req_ready_o !== 1'b1 || dm_resp_ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release: req_ready %b dm_resp_ready %b expected 1 1", req_ready_o, dm_resp_ready_o);
        end
    endtask

    task automatic test_read_fwd();
        send(7'h11, dm::DTM_READ, 32'd0);
        tests_run++;
        if (dm_req_valid_o !== 1'b1 || dm_req_o.addr !== 7'h11 || dm_req_o.op !== dm::DTM_READ) begin
            failures++;
            $display("[TB] FAIL read_fwd_req: valid %b addr %h op %0d expected 1 11 1", dm_req_valid_o, dm_req_o.addr, dm_req_o.op);
        end
        dm_answer(32'hCAFE0001, 2'd0);
        tests_run++;
        if (resp_valid_o !== 1'b1 || resp_o !== {32'hCAFE0001, 2'd0} || deny_cnt_o !== 8'd0) begin
            failures++;
            $display("[TB] FAIL read_fwd_resp: valid %b resp %h cnt %0d expected 1 %h 0", resp_valid_o, resp_o, deny_cnt_o, {32'hCAFE0001, 2'd0});
        end
        finish_resp();
        tests_run++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL read_fwd_done: resp_valid %b req_ready %b expected 0 1", resp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_write_policy();
        send(7'h10, dm::DTM_WRITE, 32'd1);
        exp_deny++;
        tests_run++;
        if (dm_req_valid_o !== 1'b0 || resp_valid_o !== 1'b0 || deny_cnt_o !== 8'(exp_deny)) begin
            failures++;
            $display("[TB] FAIL write_locked_deny: dm_valid %b resp_valid %b cnt %0d expected 0 0 %0d", dm_req_valid_o, resp_valid_o, deny_cnt_o, exp_deny);
        end
        @(negedge clk_i);
        tests_run++;
        if (resp_valid_o !== 1'b1 || resp_o !== {32'd0, 2'd2}) begin
            failures++;
            $display("[TB] FAIL write_locked_resp: valid %b resp %h expected 1 %h", resp_valid_o, resp_o, {32'd0, 2'd2});
        end
        finish_resp();
        pulse_unlock();
        send(7'h10, dm::DTM_WRITE, 32'd1);
        tests_run++;
        if (unlocked_o !== 1'b1 || dm_req_valid_o !== 1'b1 || dm_req_o.data !== 32'd1 || dm_req_o.op !== dm::DTM_WRITE) begin
            failures++;
            $display("[TB] FAIL write_unlocked_fwd: unlocked %b valid %b data %h op %0d expected 1 1 1 2", unlocked_o, dm_req_valid_o, dm_req_o.data, dm_req_o.op);
        end
        dm_answer(32'h0000_005A, 2'd0);
        tests_run++;
        if (resp_o !== {32'h0000_005A, 2'd0} || deny_cnt_o !== 8'(exp_deny)) begin
            failures++;
            $display("[TB] FAIL write_unlocked_resp: resp %h cnt %0d expected %h %0d", resp_o, deny_cnt_o, {32'h0000_005A, 2'd0}, exp_deny);
        end
        finish_resp();
        pulse_lock();
    endtask

    task automatic test_read_policy();
        logic [6:0] addrs [3] = '{7'h3C, 7'h38, 7'h37};
        logic       deny  [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            send(addrs[i], dm::DTM_READ, 32'd0);
            if (deny[i]) begin
                exp_deny++;
                @(negedge clk_i);
                tests_run++;
                if (resp_valid_o !== 1'b1 || resp_o !== {32'd0, 2'd2} || deny_cnt_o !== 8'(exp_deny)) begin
                    failures++;
                    $display("[TB] FAIL read_locked_deny_%h: valid %b resp %h cnt %0d expected 1 %h %0d", addrs[i], resp_valid_o, resp_o, deny_cnt_o, {32'd0, 2'd2}, exp_deny);
                end
            end else begin
                tests_run++;
                if (dm_req_valid_o !== 1'b1 || dm_req_o.addr !== addrs[i]) begin
                    failures++;
                    $display("[TB] FAIL read_locked_fwd_%h: valid %b addr %h expected 1 %h", addrs[i], dm_req_valid_o, dm_req_o.addr, addrs[i]);
                end
                dm_answer(32'h1234_0037, 2'd0);
            end
            finish_resp();
        end
        send(7'h05, dm::dtm_op_e'(2'd3), 32'd0);
        exp_deny++;
        @(negedge clk_i);
        tests_run++;
        if (resp_o !== {32'd0, 2'd2} || deny_cnt_o !== 8'(exp_deny)) begin
            failures++;
            $display("[TB] FAIL bad_op_deny: resp %h cnt %0d expected %h %0d", resp_o, deny_cnt_o, {32'd0, 2'd2}, exp_deny);
        end
        finish_resp();
        pulse_unlock();
        send(7'h3C, dm::DTM_READ, 32'd0);
        tests_run++;
        if (dm_req_valid_o !== 1'b1 || dm_req_o.addr !== 7'h3C) begin
            failures++;
            $display("[TB] FAIL read_unlocked_fwd: valid %b addr %h expected 1 3c", dm_req_valid_o, dm_req_o.addr);
        end
        dm_answer(32'hABCD_0003, 2'd0);
        finish_resp();
        unlock_set_i = 1'b1;
        lock_clr_i   = 1'b1;
        @(negedge clk_i);
        unlock_set_i = 1'b0;
        lock_clr_i   = 1'b0;
        tests_run++;
        if (unlocked_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lock_wins: unlocked %b expected 0", unlocked_o);
        end
    endtask

    task automatic test_timeouts();
        int cnt;
        // DM never accepts the request.
        send(7'h11, dm::DTM_READ, 32'd0);
        cnt = 0;
        while (timeout_o !== 1'b1 && cnt < 2000) begin
            @(negedge clk_i);
            cnt++;
        end
        tests_run++;
        if (cnt !== 1024 || resp_valid_o !== 1'b1 || resp_o !== {32'd0, 2'd2} || dm_req_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fwd_timeout: cycles %0d valid %b resp %h dm_valid %b expected 1024 1 %h 0", cnt, resp_valid_o, resp_o, dm_req_valid_o, {32'd0, 2'd2});
        end
        @(negedge clk_i);
        tests_run++;
        if (timeout_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_pulse: timeout %b expected 0", timeout_o);
        end
        finish_resp();
        send(7'h11, dm::DTM_READ, 32'd0);
        tests_run++;
        if (dm_req_valid_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fwd_timeout_no_late: dm_valid %b expected 1", dm_req_valid_o);
        end
        // Response lands on the final timer cycle: on time, no abort.
        dm_req_ready_i = 1'b1;
        @(negedge clk_i);
        dm_req_ready_i = 1'b0;
        repeat (1023) @(negedge clk_i);
        dm_resp_i       = '{data: 32'h0000_0BAD, resp: 2'd0};
        dm_resp_valid_i = 1'b1;
        @(negedge clk_i);
        dm_resp_valid_i = 1'b0;
        tests_run++;
        if (timeout_o !== 1'b0 || resp_valid_o !== 1'b1 || resp_o !== {32'h0000_0BAD, 2'd0}) begin
            failures++;
            $display("[TB] FAIL edge_on_time: timeout %b valid %b resp %h expected 0 1 %h", timeout_o, resp_valid_o, resp_o, {32'h0000_0BAD, 2'd0});
        end
        finish_resp();
        // DM accepts but never answers.
        send(7'h11, dm::DTM_READ, 32'd0);
        tests_run++;
        if (dm_req_valid_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL edge_no_late: dm_valid %b expected 1", dm_req_valid_o);
        end
        dm_req_ready_i = 1'b1;
        @(negedge clk_i);
        dm_req_ready_i = 1'b0;
        cnt = 0;
        while (timeout_o !== 1'b1 && cnt < 2000) begin
            @(negedge clk_i);
            cnt++;
        end
        tests_run++;
        if (cnt !== 1024 || resp_o !== {32'd0, 2'd2}) begin
            failures++;
            $display("[TB] FAIL wait_timeout: cycles %0d resp %h expected 1024 %h", cnt, resp_o, {32'd0, 2'd2});
        end
        finish_resp();
        send(7'h11, dm::DTM_READ, 32'd0);
        exp_deny++;
        @(negedge clk_i);
        tests_run++;
        if (resp_o !== {32'd0, 2'd3} || deny_cnt_o !== 8'(exp_deny)) begin
            failures++;
            $display("[TB] FAIL late_busy: resp %h cnt %0d expected %h %0d", resp_o, deny_cnt_o, {32'd0, 2'd3}, exp_deny);
        end
        finish_resp();
        dm_resp_i       = '{data: 32'hDEAD_BEEF, resp: 2'd0};
        dm_resp_valid_i = 1'b1;
        @(negedge clk_i);
        dm_resp_valid_i = 1'b0;
        send(7'h11, dm::DTM_READ, 32'd0);
        tests_run++;
        if (resp_valid_o !== 1'b0 || dm_req_valid_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL late_discard: resp_valid %b dm_valid %b expected 0 1", resp_valid_o, dm_req_valid_o);
        end
        dm_answer(32'h0000_BEEF, 2'd0);
        tests_run++;
        if (resp_o !== {32'h0000_BEEF, 2'd0}) begin
            failures++;
            $display("[TB] FAIL after_late_resp: resp %h expected %h", resp_o, {32'h0000_BEEF, 2'd0});
        end
        finish_resp();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            send(7'h20, dm::DTM_WRITE, 32'd0);
            @(negedge clk_i);
            finish_resp();
            exp_deny = (exp_deny < 255) ? exp_deny + 1 : 255;
        end
        tests_run++;
        if (deny_cnt_o !== 8'd255 || exp_deny != 255) begin
            failures++;
            $display("[TB] FAIL deny_saturate: cnt %0d expected 255", deny_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        send(7'h20, dm::DTM_WRITE, 32'd0);
        @(negedge clk_i);
        req_i       = '{addr: 7'h11, op: dm::DTM_READ, data: 32'd0};
        req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (resp_valid_o !== 1'b1 || resp_o !== {32'd0, 2'd2} || req_ready_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_resp_%0d: valid %b resp %h req_ready %b expected 1 %h 0", i, resp_valid_o, resp_o, req_ready_o, {32'd0, 2'd2});
            end
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        finish_resp();
        tests_run++;
        if (req_ready_o !== 1'b1 || dm_req_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_release: req_ready %b dm_valid %b expected 1 0", req_ready_o, dm_req_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        pulse_unlock();
        send(7'h11, dm::DTM_READ, 32'd0);
        dm_req_ready_i = 1'b1;
        @(negedge clk_i);
        dm_req_ready_i = 1'b0;
        rst_i = 1'b1;
        #1;
        tests_run++;
        if ({req_ready_o, resp_valid_o, dm_req_valid_o, dm_resp_ready_o, unlocked_o} !== 5'b0 ||
            deny_cnt_o !== 8'd0 || resp_o !== '0 || dm_req_o !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid: ctrl %b cnt %0d resp %h dm_req %h expected 0 0 0 0",
                     {req_ready_o, resp_valid_o, dm_req_valid_o, dm_resp_ready_o, unlocked_o}, deny_cnt_o, resp_o, dm_req_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_deny = 0;
        @(negedge clk_i);
        tests_run++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_mid_idle: req_ready %b expected 1", req_ready_o);
        end
        dm_resp_i       = '{data: 32'h5555_AAAA, resp: 2'd0};
        dm_resp_valid_i = 1'b1;
        @(negedge clk_i);
        dm_resp_valid_i = 1'b0;
        send(7'h11, dm::DTM_READ, 32'd0);
        tests_run++;
        if (resp_valid_o !== 1'b0 || dm_req_valid_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stray_discard: resp_valid %b dm_valid %b expected 0 1", resp_valid_o, dm_req_valid_o);
        end
        dm_answer(32'h0000_0077, 2'd0);
        tests_run++;
        if (resp_o !== {32'h0000_0077, 2'd0} || deny_cnt_o !== 8'd0) begin
            failures++;
            $display("[TB] FAIL after_reset_resp: resp %h cnt %0d expected %h 0", resp_o, deny_cnt_o, {32'h0000_0077, 2'd0});
        end
        finish_resp();
    endtask

    initial begin
        test_reset();
        test_read_fwd();
        test_write_policy();
        test_read_policy();
        test_timeouts();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
